// File: rtl/nibble_dispenser_pkg.sv
//------------------------------------------------------------------------------
// nibble_dispenser_pkg : shared types and constants for the nibble dispenser
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package nibble_dispenser_pkg;

  localparam int SUM_W     = 8;
  localparam int DATA_W    = 4;
  localparam int CHUNKS_W  = 5;
  localparam int MAX_CHUNK = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : nibble_dispenser_pkg

`default_nettype wire

// File: rtl/dispense_datapath.sv
//------------------------------------------------------------------------------
// dispense_datapath : remaining/chunk-count registers with min/subtract logic
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dispense_datapath #(
  parameter int SUM_W    = nibble_dispenser_pkg::SUM_W,
  parameter int DATA_W   = nibble_dispenser_pkg::DATA_W,
  parameter int CHUNKS_W = nibble_dispenser_pkg::CHUNKS_W
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                load,
  input  logic                sub,
  input  logic                clr,
  input  logic [SUM_W-1:0]    total,
  output logic [SUM_W-1:0]    remaining,
  output logic [CHUNKS_W-1:0] chunks,
  output logic [DATA_W-1:0]   chunk,
  output logic                last
);

  localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'((1 << DATA_W) - 1);

  // The emitted chunk never exceeds remaining, so the subtract cannot wrap.
  always_comb begin
    last  = (remaining <= MAX_SUM);
    chunk = last ? remaining[DATA_W-1:0] : MAX_SUM[DATA_W-1:0];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      chunks    <= '0;
    end else if (clr) begin
      remaining <= '0;
      chunks    <= '0;
    end else if (load) begin
      remaining <= total;
      chunks    <= '0;
    end else if (sub) begin
      remaining <= remaining - SUM_W'(chunk);
      chunks    <= chunks + 1'b1;
    end
  end

endmodule : dispense_datapath

`default_nettype wire

// File: rtl/nibble_dispenser.sv
//------------------------------------------------------------------------------
// nibble_dispenser : splits a loaded total into valid/ready chunks of <= 15
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module nibble_dispenser #(
  parameter int SUM_W  = nibble_dispenser_pkg::SUM_W,
  parameter int DATA_W = nibble_dispenser_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SUM_W-1:0]  total,
  input  logic              abort,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic [SUM_W-1:0]  remaining,
  output logic [4:0]        chunks,
  output logic              done,
  output logic              busy
);

  import nibble_dispenser_pkg::*;

  state_t            state;
  state_t            state_nxt;
  logic              load;
  logic              sub;
  logic              clr;
  logic              last;
  logic [DATA_W-1:0] chunk;

  dispense_datapath #(
    .SUM_W    (SUM_W),
    .DATA_W   (DATA_W),
    .CHUNKS_W (5)
  ) u_datapath (
    .clock     (clock),
    .rst_n     (rst_n),
    .load      (load),
    .sub       (sub),
    .clr       (clr),
    .total     (total),
    .remaining (remaining),
    .chunks    (chunks),
    .chunk     (chunk),
    .last      (last)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Abort outranks transfer, so a cancelled cycle never moves data.
  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    sub        = 1'b0;
    clr        = 1'b0;
    data_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    data       = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (total != '0) begin
            load      = 1'b1;
            state_nxt = SEND;
          end else begin
            clr       = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      SEND: begin
        data_valid = 1'b1;
        busy       = 1'b1;
        data       = chunk;
        if (abort) begin
          state_nxt = IDLE;
        end else if (data_ready) begin
          sub = 1'b1;
          if (last) state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule : nibble_dispenser

`default_nettype wire

// File: tb/tb_nibble_dispenser.sv
//------------------------------------------------------------------------------
// tb_nibble_dispenser : table-driven loopback vectors plus corner sequences
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_nibble_dispenser;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] total = '0;
  logic       abort = 1'b0;
  logic       data_ready = 1'b0;
  logic [3:0] data;
  logic       data_valid;
  logic [7:0] remaining;
  logic [4:0] chunks;
  logic       done;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  nibble_dispenser #(.SUM_W(8), .DATA_W(4)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .start      (start),
    .total      (total),
    .abort      (abort),
    .data_ready (data_ready),
    .data       (data),
    .data_valid (data_valid),
    .remaining  (remaining),
    .chunks     (chunks),
    .done       (done),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] total;
    int         exp_chunks;
    int         exp_last;
  } vec_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Runs one dispense; the collector sums every chunk that crosses an edge.
  task automatic run_op(input logic [7:0] tot, input bit toggle, input bit hold_start,
                        output int sum, output int n, output int last, output int cycles,
                        output int unstable);
    logic [3:0] held;
    bit         rdy;
    sum = 0; n = 0; last = 0; cycles = 0; unstable = 0; rdy = 1'b1;
    start = 1'b1; total = tot; data_ready = 1'b1;
    tick();
    cycles = 1;
    if (!hold_start) start = 1'b0;
    total = 8'd7;
    while (!done && cycles < 80) begin
      if (toggle) data_ready = rdy;
      held = data;
      if (data_valid && data_ready) begin
        sum += int'(data); n++; last = int'(data);
      end
      tick();
      cycles++;
      if (toggle && !rdy && (!data_valid || data != held)) unstable++;
      rdy = ~rdy;
    end
    start = 1'b0;
    data_ready = 1'b1;
  endtask

  initial begin
    vec_t vecs[8];
    int sum, n, last, cycles, unstable;

    vecs[0] = '{8'd40,  3,  10};
    vecs[1] = '{8'd0,   0,  0};
    vecs[2] = '{8'd1,   1,  1};
    vecs[3] = '{8'd15,  1,  15};
    vecs[4] = '{8'd16,  2,  1};
    vecs[5] = '{8'd200, 14, 5};
    vecs[6] = '{8'd255, 17, 15};
    vecs[7] = '{8'd30,  2,  15};

    #12;
    check("reset_valid", int'(data_valid), 0);
    check("reset_busy",  int'(busy), 0);
    check("reset_done",  int'(done), 0);
    check("reset_data",  int'(data), 0);
    check("reset_rem",   int'(remaining), 0);
    check("reset_chunks", int'(chunks), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].total, 1'b0, 1'b0, sum, n, last, cycles, unstable);
      check($sformatf("v%0d_done", i), int'(done), 1);
      check($sformatf("v%0d_sum", i), sum, int'(vecs[i].total));
      check($sformatf("v%0d_n", i), n, vecs[i].exp_chunks);
      check($sformatf("v%0d_chunks", i), int'(chunks), vecs[i].exp_chunks);
      check($sformatf("v%0d_last", i), last, vecs[i].exp_last);
      check($sformatf("v%0d_latency", i), cycles, vecs[i].exp_chunks + 1);
      check($sformatf("v%0d_valid_in_done", i), int'(data_valid), 0);
      check($sformatf("v%0d_rem", i), int'(remaining), 0);
      tick();
      check($sformatf("v%0d_done_pulse", i), int'(done), 0);
      check($sformatf("v%0d_chunks_hold", i), int'(chunks), vecs[i].exp_chunks);
    end

    // 255 with toggling ready and start held high through SEND and DONE
    run_op(8'd255, 1'b1, 1'b1, sum, n, last, cycles, unstable);
    check("tog_sum", sum, 255);
    check("tog_chunks", int'(chunks), 17);
    check("tog_stable", unstable, 0);
    tick();
    check("tog_idle_busy", int'(busy), 0);
    check("tog_rem_hold", int'(remaining), 0);

    // abort after two transfers
    start = 1'b1; total = 8'd100; data_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort_pre_rem", int'(remaining), 70);
    abort = 1'b1;
    start = 1'b1; total = 8'd9;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_rem", int'(remaining), 70);
    check("abort_chunks", int'(chunks), 2);
    check("abort_done", int'(done), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle_noeff", int'(busy), 0);
    run_op(8'd5, 1'b0, 1'b0, sum, n, last, cycles, unstable);
    check("post_abort_sum", sum, 5);
    check("post_abort_n", n, 1);
    check("post_abort_lat", cycles, 2);
    tick();

    // asynchronous reset between edges during SEND
    start = 1'b1; total = 8'd200;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(data_valid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_data", int'(data), 0);
    check("arst_rem", int'(remaining), 0);
    check("arst_chunks", int'(chunks), 0);
    start = 1'b1;
    tick();
    check("arst_start_ignored", int'(busy), 0);
    check("arst_done", int'(done), 0);
    start = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    check("arst_stay_idle", int'(busy), 0);
    run_op(8'd16, 1'b0, 1'b0, sum, n, last, cycles, unstable);
    check("arst_resume_sum", sum, 16);
    check("arst_resume_chunks", int'(chunks), 2);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_nibble_dispenser

`default_nettype wire
